// File: rtl/dmem_ctrl_pkg.sv
// Shared types for the data-memory controller: access sizes, FSM state encoding,
// master indices and the access legality check.
package dmem_ctrl_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_ILL  = 2'b11
  } size_e;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_RD_ISSUE  = 3'd1,
    ST_RD_WAIT   = 3'd2,
    ST_RMW_RD    = 3'd3,
    ST_RMW_MERGE = 3'd4
  } state_e;

  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

  function automatic logic [31:0] word_addr(input logic [31:0] addr);
    return {2'b00, addr[31:2]};
  endfunction

  // Illegal size, misaligned half/word, or beyond the end of the memory.
  function automatic logic cmd_reject(input size_e size, input logic [31:0] addr,
                                      input int unsigned depth);
    logic misaligned;
    misaligned = ((size == SZ_HALF) && addr[0]) ||
                 ((size == SZ_WORD) && (addr[1:0] != 2'b00));
    return (size == SZ_ILL) || misaligned || (word_addr(addr) >= depth);
  endfunction

endpackage

// File: rtl/dmem_ctrl_if.sv
// Request/response bus between the two masters (core, debug) and dmem_ctrl.
// Per-master fields are packed {m1,m0}.
interface dmem_ctrl_if;
  logic [1:0]  i_Req;
  logic [1:0]  i_We;
  logic [3:0]  i_Size;
  logic [1:0]  i_Unsigned;
  logic [63:0] i_Addr;
  logic [63:0] i_WData;
  logic [1:0]  o_Gnt;
  logic [1:0]  o_Done;
  logic        o_Err;
  logic [31:0] o_RData;

  modport master (
    output i_Req, i_We, i_Size, i_Unsigned, i_Addr, i_WData,
    input  o_Gnt, o_Done, o_Err, o_RData
  );

  modport slave (
    input  i_Req, i_We, i_Size, i_Unsigned, i_Addr, i_WData,
    output o_Gnt, o_Done, o_Err, o_RData
  );
endinterface

// File: rtl/dmem_lane_fmt.sv
// Byte/half lane handling: extracts and extends a load lane, and merges a store
// lane into a read word (little-endian, byte lane n = bits 8n+7:8n).
module dmem_lane_fmt
  import dmem_ctrl_pkg::*;
(
  input  logic [31:0] mem_word,
  input  logic [31:0] store_data,
  input  size_e       size,
  input  logic        is_unsigned,
  input  logic [1:0]  byte_off,
  output logic [31:0] load_data,
  output logic [31:0] merged_word
);

  logic [4:0]  bit_off;
  logic [31:0] shifted;
  logic [31:0] lane_mask;

  always_comb begin
    bit_off   = {byte_off, 3'b000};
    shifted   = mem_word >> bit_off;
    load_data = shifted;
    lane_mask = 32'hFFFF_FFFF;
    case (size)
      SZ_BYTE: begin
        load_data = is_unsigned ? {24'h0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
        lane_mask = 32'h0000_00FF << bit_off;
      end
      SZ_HALF: begin
        load_data = is_unsigned ? {16'h0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
        lane_mask = 32'h0000_FFFF << bit_off;
      end
      default: ;
    endcase
    merged_word = (mem_word & ~lane_mask) | ((store_data << bit_off) & lane_mask);
  end

endmodule

// File: rtl/dmem_ctrl.sv
// Two-master data-memory controller with sub-word read-modify-write.
// Define DMEM_CTRL_RR_EN for round-robin arbitration; default is fixed m0 priority.
//
// state        | meaning
// ST_IDLE      | accepting requests; word stores and rejects complete from here
// ST_RD_ISSUE  | load read enable on the memory
// ST_RD_WAIT   | load data returning, lane extracted into o_RData
// ST_RMW_RD    | sub-word store: read of the target word
// ST_RMW_MERGE | sub-word store: lane merged, write issued
module dmem_ctrl
  import dmem_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH = 1024
) (
  input  logic        i_Clk,
  input  logic        i_Rst,
  dmem_ctrl_if.slave  bus,
  output logic        o_Mem_WriteEn,
  output logic [31:0] o_Mem_Write_Addr,
  output logic [31:0] o_Mem_Write_Data,
  output logic        o_Mem_ReadEn,
  output logic [31:0] o_Mem_Read_Addr,
  input  logic [31:0] i_Mem_Read_Data
);

  state_e      state_q, state_d;
  logic        pick;
  logic        gnt_any;
  logic        req_we, req_uns, req_reject;
  size_e       req_size;
  logic [31:0] req_addr, req_wdata;

  logic        cmd_m_q, cmd_uns_q;
  size_e       cmd_size_q;
  logic [31:0] cmd_addr_q, cmd_wdata_q;

  logic        mem_we_q, mem_we_d, mem_re_q, mem_re_d;
  logic [31:0] mem_waddr_q, mem_waddr_d, mem_wdata_q, mem_wdata_d;
  logic [31:0] mem_raddr_q, mem_raddr_d;
  logic [1:0]  done_q, done_d;
  logic        err_q, err_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] fmt_load, fmt_merged;

`ifdef DMEM_CTRL_RR_EN
  logic last_gnt_q;

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      last_gnt_q <= M1;
    end else if (gnt_any) begin
      last_gnt_q <= pick;
    end
  end

  assign pick = (&bus.i_Req) ? ~last_gnt_q : bus.i_Req[1];
`else
  assign pick = ~bus.i_Req[0];
`endif

  assign gnt_any    = (state_q == ST_IDLE) && (bus.i_Req != 2'b00) && !i_Rst;
  assign bus.o_Gnt  = gnt_any ? (pick ? 2'b10 : 2'b01) : 2'b00;

  assign req_we     = pick ? bus.i_We[1]        : bus.i_We[0];
  assign req_uns    = pick ? bus.i_Unsigned[1]  : bus.i_Unsigned[0];
  assign req_size   = size_e'(pick ? bus.i_Size[3:2] : bus.i_Size[1:0]);
  assign req_addr   = pick ? bus.i_Addr[63:32]  : bus.i_Addr[31:0];
  assign req_wdata  = pick ? bus.i_WData[63:32] : bus.i_WData[31:0];
  assign req_reject = cmd_reject(req_size, req_addr, DEPTH);

  dmem_lane_fmt u_lane_fmt (
    .mem_word    (i_Mem_Read_Data),
    .store_data  (cmd_wdata_q),
    .size        (cmd_size_q),
    .is_unsigned (cmd_uns_q),
    .byte_off    (cmd_addr_q[1:0]),
    .load_data   (fmt_load),
    .merged_word (fmt_merged)
  );

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state_q     <= ST_IDLE;
      cmd_m_q     <= M0;
      cmd_uns_q   <= 1'b0;
      cmd_size_q  <= SZ_BYTE;
      cmd_addr_q  <= '0;
      cmd_wdata_q <= '0;
      mem_we_q    <= 1'b0;
      mem_re_q    <= 1'b0;
      mem_waddr_q <= '0;
      mem_wdata_q <= '0;
      mem_raddr_q <= '0;
      done_q      <= 2'b00;
      err_q       <= 1'b0;
      rdata_q     <= '0;
    end else begin
      state_q <= state_d;
      if (gnt_any) begin
        cmd_m_q     <= pick;
        cmd_uns_q   <= req_uns;
        cmd_size_q  <= req_size;
        cmd_addr_q  <= req_addr;
        cmd_wdata_q <= req_wdata;
      end
      mem_we_q    <= mem_we_d;
      mem_re_q    <= mem_re_d;
      mem_waddr_q <= mem_waddr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_raddr_q <= mem_raddr_d;
      done_q      <= done_d;
      err_q       <= err_d;
      rdata_q     <= rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (gnt_any && !req_reject) begin
          if (!req_we) begin
            state_d = ST_RD_ISSUE;
          end else if (req_size != SZ_WORD) begin
            state_d = ST_RMW_RD;
          end
        end
      end
      ST_RD_ISSUE:  state_d = ST_RD_WAIT;
      ST_RD_WAIT:   state_d = ST_IDLE;
      ST_RMW_RD:    state_d = ST_RMW_MERGE;
      ST_RMW_MERGE: state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs; enables default low, addresses hold.
  always_comb begin
    mem_we_d    = 1'b0;
    mem_re_d    = 1'b0;
    mem_waddr_d = mem_waddr_q;
    mem_wdata_d = mem_wdata_q;
    mem_raddr_d = mem_raddr_q;
    done_d      = 2'b00;
    err_d       = 1'b0;
    rdata_d     = rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (gnt_any) begin
          if (req_reject) begin
            done_d = pick ? 2'b10 : 2'b01;
            err_d  = 1'b1;
          end else if (req_we && (req_size == SZ_WORD)) begin
            mem_we_d    = 1'b1;
            mem_waddr_d = word_addr(req_addr);
            mem_wdata_d = req_wdata;
            done_d      = pick ? 2'b10 : 2'b01;
          end else begin
            mem_re_d    = 1'b1;
            mem_raddr_d = word_addr(req_addr);
          end
        end
      end
      ST_RD_WAIT: begin
        rdata_d = fmt_load;
        done_d  = (cmd_m_q == M1) ? 2'b10 : 2'b01;
      end
      ST_RMW_MERGE: begin
        mem_we_d    = 1'b1;
        mem_waddr_d = word_addr(cmd_addr_q);
        mem_wdata_d = fmt_merged;
        done_d      = (cmd_m_q == M1) ? 2'b10 : 2'b01;
      end
      default: ;
    endcase
  end

  assign o_Mem_WriteEn    = mem_we_q;
  assign o_Mem_Write_Addr = mem_waddr_q;
  assign o_Mem_Write_Data = mem_wdata_q;
  assign o_Mem_ReadEn     = mem_re_q;
  assign o_Mem_Read_Addr  = mem_raddr_q;
  assign bus.o_Done       = done_q;
  assign bus.o_Err        = err_q;
  assign bus.o_RData      = rdata_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Bench for dmem_ctrl: DataMem model with 1-cycle registered read, reference
// memory plus scoreboard of completions. Compile with DMEM_CTRL_RR_EN to match RTL.
module tb_dmem_ctrl;
  import dmem_ctrl_pkg::*;

  localparam int unsigned DEPTH  = 64;
  localparam int unsigned ADDR_W = $clog2(DEPTH);

  typedef struct {
    logic [1:0]  done;
    logic        err;
    logic        is_load;
    logic [31:0] rdata;
    logic        is_store;
    logic [31:0] waddr;
    logic [31:0] wdata;
  } exp_t;

  logic        i_Clk = 1'b0;
  logic        i_Rst;
  logic        mem_we, mem_re;
  logic [31:0] mem_waddr, mem_wdata, mem_raddr, mem_rdata;
  logic        init_mem;
  logic [31:0] mem     [DEPTH];
  logic [31:0] ref_mem [DEPTH];
  exp_t        sb_q[$];
  exp_t        mon_e;
  int          n_cmp = 0;
  int          n_mis = 0;
  int          re_cycles = 0, we_cycles = 0, exp_re = 0, exp_we = 0;
  logic [31:0] last_rdata = 32'h0;

  dmem_ctrl_if bus();

  dmem_ctrl #(.DEPTH(DEPTH)) dut (
    .i_Clk            (i_Clk),
    .i_Rst            (i_Rst),
    .bus              (bus),
    .o_Mem_WriteEn    (mem_we),
    .o_Mem_Write_Addr (mem_waddr),
    .o_Mem_Write_Data (mem_wdata),
    .o_Mem_ReadEn     (mem_re),
    .o_Mem_Read_Addr  (mem_raddr),
    .i_Mem_Read_Data  (mem_rdata)
  );

  always #5 i_Clk = ~i_Clk;

  always @(posedge i_Clk) begin
    if (init_mem) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= 32'h0;
    end else begin
      if (mem_we) mem[mem_waddr[ADDR_W-1:0]] <= mem_wdata;
      if (mem_re) mem_rdata <= mem[mem_raddr[ADDR_W-1:0]];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [1:0] off,
                                           input logic [1:0] sz, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    case (off)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    h = off[1] ? w[31:16] : w[15:0];
    case (sz)
      2'b00:   return uns ? {24'h0, b} : {{24{b[7]}}, b};
      2'b01:   return uns ? {16'h0, h} : {{16{h[15]}}, h};
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] ref_merge(input logic [31:0] w, input logic [1:0] off,
                                            input logic [1:0] sz, input logic [31:0] d);
    logic [31:0] r;
    r = w;
    if (sz == 2'b00) begin
      case (off)
        2'd0:    r[7:0]   = d[7:0];
        2'd1:    r[15:8]  = d[7:0];
        2'd2:    r[23:16] = d[7:0];
        default: r[31:24] = d[7:0];
      endcase
    end else if (sz == 2'b01) begin
      if (off[1]) r[31:16] = d[15:0];
      else        r[15:0]  = d[15:0];
    end else begin
      r = d;
    end
    return r;
  endfunction

  function automatic logic ref_reject(input logic [1:0] sz, input logic [31:0] addr);
    return (sz == 2'b11) || ((sz == 2'b01) && addr[0]) ||
           ((sz == 2'b10) && (addr[1:0] != 2'b00)) || (addr[31:2] >= 30'(DEPTH));
  endfunction

  // Reference model: push the expected completion and update the reference memory.
  task automatic model(input logic m, input logic we, input logic [1:0] sz, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wd, output int lat);
    exp_t        e;
    logic [31:0] wa;
    wa         = {2'b00, addr[31:2]};
    e.done     = m ? 2'b10 : 2'b01;
    e.err      = 1'b0;
    e.is_load  = 1'b0;
    e.is_store = 1'b0;
    e.rdata    = 32'h0;
    e.waddr    = wa;
    e.wdata    = 32'h0;
    if (ref_reject(sz, addr)) begin
      e.err = 1'b1;
      lat   = 1;
    end else if (!we) begin
      e.is_load  = 1'b1;
      e.rdata    = ref_load(ref_mem[wa[ADDR_W-1:0]], addr[1:0], sz, uns);
      last_rdata = e.rdata;
      lat        = 3;
      exp_re++;
    end else begin
      e.is_store = 1'b1;
      e.wdata    = ref_merge(ref_mem[wa[ADDR_W-1:0]], addr[1:0], sz, wd);
      ref_mem[wa[ADDR_W-1:0]] = e.wdata;
      exp_we++;
      if (sz == 2'b10) begin
        lat = 1;
      end else begin
        lat = 3;
        exp_re++;
      end
    end
    sb_q.push_back(e);
  endtask

  task automatic drive(input logic m, input logic we, input logic [1:0] sz, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wd);
    if (m) begin
      bus.i_Req[1] = 1'b1; bus.i_We[1] = we; bus.i_Size[3:2] = sz;
      bus.i_Unsigned[1] = uns; bus.i_Addr[63:32] = addr; bus.i_WData[63:32] = wd;
    end else begin
      bus.i_Req[0] = 1'b1; bus.i_We[0] = we; bus.i_Size[1:0] = sz;
      bus.i_Unsigned[0] = uns; bus.i_Addr[31:0] = addr; bus.i_WData[31:0] = wd;
    end
  endtask

  // Single request; returns in the completion cycle (sampled 1 after the edge).
  task automatic do_req(input string tag, input logic m, input logic we, input logic [1:0] sz,
                        input logic uns, input logic [31:0] addr, input logic [31:0] wd);
    int   lat_exp, lat;
    logic legal;
    drive(m, we, sz, uns, addr, wd);
    model(m, we, sz, uns, addr, wd, lat_exp);
    @(negedge i_Clk);
    check({tag, "_gnt"}, {30'b0, bus.o_Gnt}, m ? 32'd2 : 32'd1);
    @(posedge i_Clk); #1;
    bus.i_Req = 2'b00;
    legal = !ref_reject(sz, addr);
    check({tag, "_re_t1"}, 32'(mem_re), 32'(legal && !(we && sz == 2'b10)));
    check({tag, "_we_t1"}, 32'(mem_we), 32'(legal && we && sz == 2'b10));
    lat = 1;
    while (bus.o_Done == 2'b00 && lat < 8) begin
      @(posedge i_Clk); #1;
      lat++;
    end
    check({tag, "_lat"}, 32'(lat), 32'(lat_exp));
  endtask

  always @(negedge i_Clk) begin
    if (!i_Rst) begin
      if (mem_re) re_cycles++;
      if (mem_we) we_cycles++;
      if (bus.o_Done != 2'b00) begin
        if (sb_q.size() == 0) begin
          check("unexpected_done", {30'b0, bus.o_Done}, 32'h0);
        end else begin
          mon_e = sb_q.pop_front();
          check("done_mask", {30'b0, bus.o_Done}, {30'b0, mon_e.done});
          check("err", 32'(bus.o_Err), 32'(mon_e.err));
          if (mon_e.is_load) check("rdata", bus.o_RData, mon_e.rdata);
          if (mon_e.is_store) begin
            check("wr_en", 32'(mem_we), 32'h1);
            check("wr_addr", mem_waddr, mon_e.waddr);
            check("wr_data", mem_wdata, mon_e.wdata);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   lat, k, cyc;
    logic exp_m;

    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'h0;
    bus.i_Req = 2'b00; bus.i_We = 2'b00; bus.i_Size = 4'h0; bus.i_Unsigned = 2'b00;
    bus.i_Addr = 64'h0; bus.i_WData = 64'h0;
    i_Rst = 1'b1;
    init_mem = 1'b1;
    repeat (2) @(posedge i_Clk);
    #1;
    drive(0, 0, 2'b10, 0, 32'h10, 0);
    drive(1, 0, 2'b10, 0, 32'h14, 0);
    @(negedge i_Clk);
    check("rst_gnt", {30'b0, bus.o_Gnt}, 32'h0);
    check("rst_done", {30'b0, bus.o_Done}, 32'h0);
    check("rst_err", 32'(bus.o_Err), 32'h0);
    check("rst_rdata", bus.o_RData, 32'h0);
    check("rst_we", 32'(mem_we), 32'h0);
    check("rst_re", 32'(mem_re), 32'h0);
    check("rst_waddr", mem_waddr, 32'h0);
    check("rst_wdata", mem_wdata, 32'h0);
    check("rst_raddr", mem_raddr, 32'h0);
    bus.i_Req = 2'b00;
    @(posedge i_Clk); #1;
    i_Rst = 1'b0;
    init_mem = 1'b0;

    do_req("sw0",    0, 1, 2'b10, 0, 32'h10, 32'hDEAD_BEEF);
    do_req("lw0",    0, 0, 2'b10, 0, 32'h10, 32'h0);
    do_req("sb0",    0, 1, 2'b00, 0, 32'h11, 32'h0000_007F);
    check("rdata_hold_store", bus.o_RData, last_rdata);
    do_req("lb",     0, 0, 2'b00, 0, 32'h13, 32'h0);
    do_req("lbu",    0, 0, 2'b00, 1, 32'h13, 32'h0);
    do_req("lh_mis", 0, 0, 2'b01, 0, 32'h13, 32'h0);
    do_req("lw_oob", 0, 0, 2'b10, 0, 32'(4 * DEPTH), 32'h0);
    check("rdata_hold_err", bus.o_RData, last_rdata);
    do_req("sz_ill", 1, 0, 2'b11, 0, 32'h20, 32'h0);
    do_req("sw_mis", 1, 1, 2'b10, 0, 32'h22, 32'h1234_5678);
    do_req("sh1",    1, 1, 2'b01, 0, 32'h12, 32'h0000_8001);
    do_req("lh1",    1, 0, 2'b01, 0, 32'h12, 32'h0);
    do_req("lhu0",   0, 0, 2'b01, 1, 32'h10, 32'h0);
    do_req("lb1",    1, 0, 2'b00, 0, 32'h10, 32'h0);
    do_req("sb1",    1, 1, 2'b00, 0, 32'h12, 32'h0000_00A5);
    do_req("lw1",    1, 0, 2'b10, 0, 32'h10, 32'h0);

    // Back-to-back word stores: a grant and a write every cycle.
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, 2'b10, 0, 32'(64 + 4 * i), 32'(32'h1000_0000 + i));
      model(0, 1, 2'b10, 0, 32'(64 + 4 * i), 32'(32'h1000_0000 + i), lat);
      @(negedge i_Clk);
      check("b2b_gnt", {30'b0, bus.o_Gnt}, 32'h1);
      @(posedge i_Clk); #1;
      check("b2b_we", 32'(mem_we), 32'h1);
    end
    bus.i_Req = 2'b00;
    @(posedge i_Clk); #1;
    check("b2b_we_end", 32'(mem_we), 32'h0);
    do_req("lw_b2b", 1, 0, 2'b10, 0, 32'h4C, 32'h0);

    // Both masters loading continuously.
    drive(0, 0, 2'b10, 0, 32'h10, 32'h0);
    drive(1, 0, 2'b10, 0, 32'h44, 32'h0);
    k = 0;
    cyc = 0;
    while (k < 4 && cyc < 40) begin
      @(negedge i_Clk);
      if (bus.o_Gnt != 2'b00) begin
`ifdef DMEM_CTRL_RR_EN
        exp_m = (k % 2) == 1;
`else
        exp_m = 1'b0;
`endif
        check("arb_gnt", {30'b0, bus.o_Gnt}, exp_m ? 32'd2 : 32'd1);
        model(exp_m, 0, 2'b10, 0, exp_m ? 32'h44 : 32'h10, 32'h0, lat);
        k++;
      end
      @(posedge i_Clk); #1;
      cyc++;
    end
    bus.i_Req = 2'b00;
    check("arb_grants", 32'(k), 32'd4);
    repeat (3) @(posedge i_Clk);
    @(negedge i_Clk);
    check("arb_drained", 32'(sb_q.size()), 32'h0);
    @(posedge i_Clk); #1;

    // Reset while a half store sits in RMW_MERGE: nothing written, nothing completed.
    do_req("sw_pre", 0, 1, 2'b10, 0, 32'h20, 32'h1122_3344);
    drive(0, 1, 2'b01, 0, 32'h22, 32'h0000_AAAA);
    @(negedge i_Clk);
    check("rmw_rst_gnt", {30'b0, bus.o_Gnt}, 32'h1);
    @(posedge i_Clk); #1;
    bus.i_Req = 2'b00;
    exp_re++;
    @(posedge i_Clk); #1;
    i_Rst = 1'b1;
    @(posedge i_Clk); #1;
    i_Rst = 1'b0;
    check("rmw_rst_we", 32'(mem_we), 32'h0);
    check("rmw_rst_done", {30'b0, bus.o_Done}, 32'h0);
    do_req("lw_post", 0, 0, 2'b10, 0, 32'h20, 32'h0);
    check("rmw_rst_mem", mem[8], 32'h1122_3344);

    repeat (2) @(posedge i_Clk);
    @(negedge i_Clk);
    check("sb_empty", 32'(sb_q.size()), 32'h0);
    check("re_cycles", 32'(re_cycles), 32'(exp_re));
    check("we_cycles", 32'(we_cycles), 32'(exp_we));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
